// File: rtl/lut4_cfg_loader.sv
// Serial-to-parallel configuration loader for a LUT4 tile: shifts in a 16-bit
// truth table MSB-first, writes it entry by entry, then optionally reads it back.
module lut4_cfg_loader #(
  parameter int HOLD_CYCLES = 1,
  parameter int VERIFY      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic       bit_ready,
  output logic [3:0] cfg_addr,
  output logic       cfg_data,
  output logic       cfg_en,
  output logic [3:0] lut_sel,
  input  logic       lut_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] err_addr
);

  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_WRITE, ST_VERIFY, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   table_q, table_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    addr_q, addr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          check_q, check_d;
  logic          bit_ready_q, bit_ready_d;
  logic [3:0]    cfg_addr_q, cfg_addr_d;
  logic          cfg_data_q, cfg_data_d;
  logic          cfg_en_q, cfg_en_d;
  logic [3:0]    lut_sel_q, lut_sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [3:0]    err_addr_q, err_addr_d;

  always_comb begin
    state_d    = state_q;
    table_d    = table_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    check_d    = check_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    case (state_q)
      ST_LOAD: begin
        if (bit_valid && bit_ready_q) begin
          table_d = {table_q[14:0], bit_data};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd0) begin
            err_d      = 1'b0;
            err_addr_d = 4'd0;
          end
          if (cnt_q == 4'd15) begin
            state_d = ST_WRITE;
            addr_d  = 4'd0;
            hold_d  = '0;
          end
        end
      end
      ST_WRITE: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (addr_q == 4'd15) begin
            addr_d  = 4'd0;
            check_d = 1'b0;
            state_d = (VERIFY != 0) ? ST_VERIFY : ST_DONE;
          end else begin
            addr_d = addr_q + 4'd1;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_VERIFY: begin
        if (!check_q) begin
          check_d = 1'b1;
        end else begin
          check_d = 1'b0;
          // Only the first mismatch of a frame is recorded.
          if ((lut_out != table_q[addr_q]) && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
          end
          if (addr_q == 4'd15) begin
            addr_d  = 4'd0;
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_LOAD;
        cnt_d   = 4'd0;
      end
      default: state_d = ST_LOAD;
    endcase

    // Outputs are decoded from the upcoming state so they are registered.
    bit_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d == ST_WRITE) || (state_d == ST_VERIFY);
    done_d      = (state_d == ST_DONE);
    cfg_en_d    = (state_d == ST_WRITE);
    cfg_addr_d  = cfg_en_d ? addr_d : cfg_addr_q;
    cfg_data_d  = cfg_en_d ? table_d[addr_d] : cfg_data_q;
    lut_sel_d   = (state_d == ST_VERIFY) ? addr_d : lut_sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      table_q     <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      hold_q      <= '0;
      check_q     <= 1'b0;
      bit_ready_q <= 1'b1;
      cfg_addr_q  <= '0;
      cfg_data_q  <= 1'b0;
      cfg_en_q    <= 1'b0;
      lut_sel_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      check_q     <= check_d;
      bit_ready_q <= bit_ready_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      cfg_en_q    <= cfg_en_d;
      lut_sel_q   <= lut_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bit_ready = bit_ready_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_en    = cfg_en_q;
  assign lut_sel   = lut_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule
